// File: rtl/nco_pkg.sv
// Shared definitions for the CORDIC NCO front end: phase width, angle constants, FSM states.
package nco_pkg;

    localparam int unsigned PHASE_W = 32;

    // Angle constants on the 2^32 = 2*pi phase circle.
    localparam logic [PHASE_W-1:0] PI_2 = 32'h4000_0000;
    localparam logic [PHASE_W-1:0] PI   = 32'h8000_0000;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } nco_state_e;

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with a count output. The head entry becomes visible on the read side
// one edge after it is written; count includes entries that are not yet visible.
module axis_sync_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      vis_ptr;
    logic             pop;
    logic             full;

    assign pop       = pop_valid & pop_ready;
    assign count     = wr_ptr - rd_ptr;
    assign full      = (count == (AW+1)'(DEPTH));
    assign pop_valid = (vis_ptr != rd_ptr);
    // Data reads as zero while empty so the stream output is all-zero after reset.
    assign pop_data  = pop_valid ? mem[rd_ptr[AW-1:0]] : '0;

    // Pointer update; vis_ptr trails wr_ptr by one edge to delay read-side visibility.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            vis_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            vis_ptr <= wr_ptr;
        end
    end

    // Storage array, no reset needed since reads are gated by the pointers.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // Upstream credit accounting must never let the FIFO overflow.
    assert property (@(posedge clock) disable iff (reset) !(push && full))
        else $error("axis_sync_fifo: push while full");

endmodule

// File: rtl/cordic_nco_frontend.sv
// Phase-accumulator NCO feeding a fixed-latency CORDIC rotator. Issued angles are tracked
// through the pipeline and the results are buffered in a FIFO behind an AXI-Stream master.
// Issue is throttled by credits so that a stalled consumer can never cause a lost sample.
module cordic_nco_frontend
    import nco_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LATENCY    = 16,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      sync,
    input  logic [PHASE_W-1:0]        cfg_ftw,
    input  logic [PHASE_W-1:0]        cfg_phase_off,
    input  logic [DATA_WIDTH-1:0]     cfg_amp,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    output logic [PHASE_W-1:0]        cordic_angle,
    output logic [DATA_WIDTH-1:0]     cordic_amp,
    output logic [DATA_WIDTH-1:0]     cordic_phase_shift,
    input  logic [DATA_WIDTH:0]       cordic_cos,
    input  logic [DATA_WIDTH:0]       cordic_sin,
    output logic [2*DATA_WIDTH+1:0]   m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      busy
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned IFL_W = $clog2(LATENCY + 2);
    localparam int unsigned CRD_W = $clog2(FIFO_DEPTH + LATENCY + 2) + 1;

    nco_state_e              state_q, state_d;
    logic [PHASE_W-1:0]      acc_q;
    logic [PHASE_W-1:0]      ftw_q;
    logic [PHASE_W-1:0]      off_q;
    logic [DATA_WIDTH-1:0]   amp_q;
    logic                    ready_q;
    logic [PHASE_W-1:0]      angle_q;
    logic [DATA_WIDTH-1:0]   amp_out_q;
    logic [LATENCY:0]        track_q;
    logic [IFL_W-1:0]        inflight_q;
    logic [CNT_W-1:0]        fifo_count;
    logic [CRD_W-1:0]        credit_used;
    logic                    issue;
    logic                    capture;

    // Same-cycle pops are not credited back, keeping the bound simple and safe.
    assign credit_used = CRD_W'(inflight_q) + CRD_W'(fifo_count);
    assign issue       = (state_q == StRun) && (credit_used < CRD_W'(FIFO_DEPTH));
    assign capture     = track_q[LATENCY];

    assign cfg_ready          = ready_q;
    assign cordic_angle       = angle_q;
    assign cordic_amp         = amp_out_q;
    assign cordic_phase_shift = '0;
    assign busy               = (state_q != StIdle);

    // Next-state logic for the run/drain sequencing.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enable) state_d = StRun;
            StRun:   if (!enable) state_d = StDrain;
            StDrain: begin
                if (enable) begin
                    state_d = StRun;
                end else if (inflight_q == '0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Config handshake and shadow registers; ready comes up on the first edge after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
            ftw_q   <= '0;
            off_q   <= '0;
            amp_q   <= '0;
        end else begin
            ready_q <= 1'b1;
            if (cfg_valid && ready_q) begin
                ftw_q <= cfg_ftw;
                off_q <= cfg_phase_off;
                amp_q <= cfg_amp;
            end
        end
    end

    // Phase accumulator and CORDIC input registers; sync wins over the increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q     <= '0;
            angle_q   <= '0;
            amp_out_q <= '0;
        end else begin
            if (issue) begin
                angle_q   <= acc_q + off_q;
                amp_out_q <= amp_q;
            end
            if (sync) begin
                acc_q <= '0;
            end else if (issue) begin
                acc_q <= acc_q + ftw_q;
            end
        end
    end

    // Tracks which CORDIC outputs belong to issued angles and how many are still in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            track_q    <= '0;
            inflight_q <= '0;
        end else begin
            track_q    <= {track_q[LATENCY-1:0], issue};
            inflight_q <= inflight_q + IFL_W'(issue) - IFL_W'(capture);
        end
    end

    axis_sync_fifo #(
        .WIDTH (2*DATA_WIDTH + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (capture),
        .push_data ({cordic_sin, cordic_cos}),
        .pop_data  (m_axis_tdata),
        .pop_valid (m_axis_tvalid),
        .pop_ready (m_axis_tready),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_cordic_nco_frontend.sv
// Bench for cordic_nco_frontend: a stand-in CORDIC (fixed-latency pipeline of a simple
// angle->{sin,cos} mapping that is exact on the quadrant angles), a transaction-level model
// of the expected beat stream, and directed scenarios with hand-computed beat values.
module tb_cordic_nco_frontend;
    import nco_pkg::*;

    localparam int DW = 16;
    localparam int L  = 16;
    localparam int D  = 32;
    localparam int TW = 2 * DW + 2;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            enable = 1'b0;
    logic            sync = 1'b0;
    logic [31:0]     cfg_ftw = '0;
    logic [31:0]     cfg_phase_off = '0;
    logic [DW-1:0]   cfg_amp = '0;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [31:0]     cordic_angle;
    logic [DW-1:0]   cordic_amp;
    logic [DW-1:0]   cordic_phase_shift;
    logic [DW:0]     cordic_cos;
    logic [DW:0]     cordic_sin;
    logic [TW-1:0]   m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b0;
    logic            busy;

    int n_chk = 0;
    int n_err = 0;
    logic chk_on = 1'b0;

    always #5 clock = ~clock;

    cordic_nco_frontend #(
        .DATA_WIDTH (DW),
        .LATENCY    (L),
        .FIFO_DEPTH (D)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .enable             (enable),
        .sync               (sync),
        .cfg_ftw            (cfg_ftw),
        .cfg_phase_off      (cfg_phase_off),
        .cfg_amp            (cfg_amp),
        .cfg_valid          (cfg_valid),
        .cfg_ready          (cfg_ready),
        .cordic_angle       (cordic_angle),
        .cordic_amp         (cordic_amp),
        .cordic_phase_shift (cordic_phase_shift),
        .cordic_cos         (cordic_cos),
        .cordic_sin         (cordic_sin),
        .m_axis_tdata       (m_axis_tdata),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tready      (m_axis_tready),
        .busy               (busy)
    );

    // Stand-in rotator result: exact on the four quadrant angles, otherwise an angle-unique code.
    function automatic logic [TW-1:0] cordic_ref(input logic [31:0] ang, input logic [DW-1:0] amp);
        logic [DW:0] a;
        logic [DW:0] c;
        logic [DW:0] s;
        a = {1'b0, amp};
        case (ang)
            32'h0000_0000: begin c = a;  s = '0; end
            PI_2:          begin c = '0; s = a;  end
            PI:            begin c = -a; s = '0; end
            32'hC000_0000: begin c = '0; s = -a; end
            default:       begin c = {1'b0, ang[31:16]}; s = {1'b0, ang[15:0] ^ amp}; end
        endcase
        return {s, c};
    endfunction

    // Stand-in CORDIC pipeline: L edges from input change to output.
    logic [TW-1:0] pipe [L];
    always @(posedge clock) begin
        pipe[0] <= cordic_ref(cordic_angle, cordic_amp);
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign {cordic_sin, cordic_cos} = pipe[L-1];

    // Transaction model: each issued sample is a queue entry; outstanding = queue length.
    typedef struct {
        logic [TW-1:0] beat;
        int            t;
    } exp_t;

    exp_t          q[$];
    int            k = 0;
    logic          run_m = 1'b0;
    logic          busy_m = 1'b0;
    logic          ready_m = 1'b0;
    logic          mvalid = 1'b0;
    logic [31:0]   acc_m = '0;
    logic [31:0]   ftw_m = '0;
    logic [31:0]   off_m = '0;
    logic [31:0]   ang_m = '0;
    logic [DW-1:0] amp_m = '0;
    logic [DW-1:0] amp_o_m = '0;
    logic [TW-1:0] got[$];

    task automatic model_step();
        logic        do_issue;
        logic        do_pop;
        int          infl;
        logic [31:0] ang;
        if (reset) begin
            q.delete();
            acc_m = '0; ftw_m = '0; off_m = '0; amp_m = '0; ang_m = '0; amp_o_m = '0;
            run_m = 1'b0; busy_m = 1'b0; ready_m = 1'b0; mvalid = 1'b0;
        end else begin
            do_pop   = mvalid && m_axis_tready;
            do_issue = run_m && (q.size() < D);
            infl = 0;
            foreach (q[i]) if (q[i].t + L + 1 >= k) infl++;
            if (do_issue) begin
                ang = acc_m + off_m;
                q.push_back('{beat: cordic_ref(ang, amp_m), t: k});
                ang_m   = ang;
                amp_o_m = amp_m;
            end
            if (sync) acc_m = '0;
            else if (do_issue) acc_m = acc_m + ftw_m;
            busy_m = enable || (busy_m && infl != 0);
            run_m  = enable;
            if (cfg_valid && ready_m) begin
                ftw_m = cfg_ftw;
                off_m = cfg_phase_off;
                amp_m = cfg_amp;
            end
            ready_m = 1'b1;
            if (do_pop) void'(q.pop_front());
            mvalid = 1'b0;
            if (q.size() > 0) mvalid = (q[0].t + L + 2 <= k);
        end
        k++;
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled mid-cycle.
    initial forever begin
        @(negedge clock);
        #1;
        if (chk_on && !reset) begin
            chk("tvalid", 64'(m_axis_tvalid), 64'(mvalid));
            if (mvalid && q.size() > 0) chk("tdata", 64'(m_axis_tdata), 64'(q[0].beat));
            chk("busy", 64'(busy), 64'(busy_m));
            chk("cfg_ready", 64'(cfg_ready), 64'(ready_m));
            chk("cordic_angle", 64'(cordic_angle), 64'(ang_m));
            chk("cordic_amp", 64'(cordic_amp), 64'(amp_o_m));
            if (m_axis_tvalid && m_axis_tready) got.push_back(m_axis_tdata);
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_cfg_ready"}, 64'(cfg_ready), 64'd0);
        chk({tag, "_angle"}, 64'(cordic_angle), 64'd0);
        chk({tag, "_amp"}, 64'(cordic_amp), 64'd0);
        chk({tag, "_phase_shift"}, 64'(cordic_phase_shift), 64'd0);
        chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        chk({tag, "_tdata"}, 64'(m_axis_tdata), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic do_cfg(input logic [31:0] ftw, input logic [31:0] off, input logic [DW-1:0] amp);
        @(negedge clock);
        cfg_ftw = ftw; cfg_phase_off = off; cfg_amp = amp; cfg_valid = 1'b1;
        @(negedge clock);
        cfg_valid = 1'b0;
    endtask

    // Waits (bounded) until the block is idle and the stream has drained.
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || m_axis_tvalid) && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk(name, 64'(busy || m_axis_tvalid), 64'd0);
    endtask

    initial begin
        int cnt;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset  = 1'b0;
        chk_on = 1'b1;
        @(negedge clock);
        chk("cfg_ready_up", 64'(cfg_ready), 64'd1);

        // Basic tone with a mid-run consumer stall.
        do_cfg(32'h0100_0000, 32'h0, 16'h4000);
        got.delete();
        m_axis_tready = 1'b1;
        @(negedge clock);
        enable = 1'b1;
        cnt = 0;
        while (!m_axis_tvalid && cnt < 100) begin
            @(negedge clock);
            cnt++;
        end
        // One edge to enter RUN, issue on the next, visible L+2 edges after the issue.
        chk("first_beat_edges", 64'(cnt), 64'(L + 4));
        repeat (300) @(negedge clock);
        m_axis_tready = 1'b0;
        repeat (100) @(negedge clock);
        m_axis_tready = 1'b1;
        repeat (100) @(negedge clock);
        enable = 1'b0;
        wait_idle("tone_idle");
        chk("tone_beat0", 64'(got[0]), 64'h0_0000_4000);
        chk("tone_beat1", 64'(got[1]), 64'h0_8000_0100);
        chk("tone_beat64", 64'(got[64]), 64'h0_8000_0000);
        chk("tone_beat256", 64'(got[256]), 64'h0_0000_4000);
        chk("tone_beat300", 64'(got[300]), 64'h0_8000_2C00);

        // Sync coincident with the issue at acc = 3000_0000.
        @(negedge clock);
        sync = 1'b1;
        @(negedge clock);
        sync = 1'b0;
        do_cfg(32'h1000_0000, 32'h0000_0100, 16'h4000);
        got.delete();
        @(negedge clock);
        enable = 1'b1;
        repeat (4) @(negedge clock);
        sync = 1'b1;
        @(negedge clock);
        sync = 1'b0;
        repeat (4) @(negedge clock);
        enable = 1'b0;
        wait_idle("sync_idle");
        chk("sync_beats", 64'(got.size()), 64'd9);
        chk("sync_beat3", 64'(got[3]), 64'h0_8200_3000);
        chk("sync_beat4", 64'(got[4]), 64'h0_8200_0000);
        chk("sync_beat5", 64'(got[5]), 64'h0_8200_1000);

        // Drain with exactly 10 samples in flight.
        got.delete();
        @(negedge clock);
        enable = 1'b1;
        repeat (10) @(negedge clock);
        enable = 1'b0;
        cnt = 0;
        while (busy && cnt < 100) begin
            @(negedge clock);
            cnt++;
        end
        // Last issue on the drop edge; captured L+1 edges later; IDLE one edge after that.
        chk("drain_edges", 64'(cnt), 64'(L + 3));
        wait_idle("drain_idle");
        chk("drain_beats", 64'(got.size()), 64'd10);

        // Fill FIFO halfway with samples in flight, then reset asynchronously mid-cycle.
        do_cfg(32'hC000_0000, 32'h0, 16'h4000);
        m_axis_tready = 1'b0;
        @(negedge clock);
        enable = 1'b1;
        repeat (34) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        got.delete();
        @(negedge clock);

        // Wrapping phase after reset: the first beats are the new sequence only.
        do_cfg(32'hC000_0000, 32'h0, 16'h4000);
        m_axis_tready = 1'b1;
        @(negedge clock);
        enable = 1'b1;
        repeat (30) @(negedge clock);
        enable = 1'b0;
        wait_idle("wrap_idle");
        chk("wrap_beat0", 64'(got[0]), 64'h0_0000_4000);
        chk("wrap_beat1", 64'(got[1]), 64'h3_8000_0000);
        chk("wrap_beat2", 64'(got[2]), 64'h0_0001_C000);
        chk("wrap_beat3", 64'(got[3]), 64'h0_8000_0000);
        chk("wrap_beat4", 64'(got[4]), 64'h0_0000_4000);

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
